mc_payoff_collector: RTL and testbench

Back-end consumer for the Monte Carlo simulation engine controller. It accepts the per-path terminal asset price stream that the engine produces while its path counter runs. For each path it computes the European call payoff max(S-K,0) and accumulates it. When the controller asserts done, it divides the sum by the accepted path count and presents the option price over a valid/ready handshake.

---
 rtl/mc_pkg.sv | 17 +
 rtl/mc_seq_divider.sv | 67 ++++++
 rtl/mc_payoff_collector.sv | 142 ++++++++++++++
 tb/tb_mc_payoff_collector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared Monte Carlo definitions: Q16.16 format, path limit and collector FSM states.
package mc_pkg;

    localparam int FRAC_BITS = 16;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 17;
    localparam int NUM_PATHS = 100000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DIVIDE,
        ST_HOLD
    } mc_state_t;

endpackage

// File: rtl/mc_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DVD_W cycles after start.
module mc_seq_divider #(
    parameter int DVD_W = 49,
    parameter int DVS_W = 17,
    parameter int QUO_W = DVD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [QUO_W-1:0] o_quotient
);

    localparam int CNT_BITS = $clog2(DVD_W + 1);

    logic [DVS_W-1:0]    r_rem;
    logic [DVS_W-1:0]    r_den;
    logic [DVD_W-1:0]    r_quo;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_busy;

    logic [DVS_W:0]   w_trial;
    logic             w_fit;
    logic [DVS_W-1:0] w_sub;
    logic             w_load;

    // Dividend shifts out of r_quo's MSB while quotient bits shift in at its LSB.
    assign w_trial = {r_rem, r_quo[DVD_W-1]};
    assign w_fit   = (w_trial >= {1'b0, r_den});
    assign w_sub   = w_trial[DVS_W-1:0] - r_den;
    assign w_load  = i_start && !r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_BITS'(DVD_W);
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_den <= i_divisor;
        end else if (r_busy && (r_cnt != '0)) begin
            r_rem <= w_fit ? w_sub : w_trial[DVS_W-1:0];
            r_quo <= {r_quo[DVD_W-2:0], w_fit};
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == '0);
    assign o_quotient = r_quo[QUO_W-1:0];

endmodule

// File: rtl/mc_payoff_collector.sv
// Accumulates European call payoffs of a Monte Carlo run and presents their mean
// over a valid/ready handshake once the engine signals done.
module mc_payoff_collector
    import mc_pkg::*;
#(
    parameter int DATA_W    = mc_pkg::DATA_W,
    parameter int CNT_W     = mc_pkg::CNT_W,
    parameter int NUM_PATHS = mc_pkg::NUM_PATHS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] strike,
    input  logic              path_valid,
    input  logic [DATA_W-1:0] path_price,
    input  logic              engine_done,
    output logic              busy,
    output logic [CNT_W-1:0]  path_count,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_price,
    output logic              err_no_paths,
    output logic              err_excess
);

    localparam int               ACC_W   = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_PATHS);

    function automatic logic [DATA_W-1:0] call_payoff(input logic [DATA_W-1:0] s,
                                                      input logic [DATA_W-1:0] k);
        return (s > k) ? (s - k) : '0;
    endfunction

    mc_state_t r_state, w_next;

    logic [DATA_W-1:0] r_strike;
    logic [DATA_W-1:0] r_pay_p1;
    logic              r_vld_p1;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_path_count;
    logic [DATA_W-1:0] r_result;
    logic              r_err_no_paths;
    logic              r_err_excess;

    logic              w_room;
    logic              w_accept;
    logic              w_excess;
    logic [ACC_W-1:0]  w_acc_sum;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [DATA_W-1:0] w_quotient;

    assign w_room    = (r_path_count < MAX_CNT);
    assign w_accept  = (r_state == ST_ACCUM) && path_valid && w_room;
    assign w_excess  = (r_state == ST_ACCUM) && path_valid && !w_room;
    // Sum including any payoff still in stage 1, so DRAIN can hand it straight to the divider.
    assign w_acc_sum = r_acc + (r_vld_p1 ? {{CNT_W{1'b0}}, r_pay_p1} : '0);
    assign w_div_start = (r_state == ST_DRAIN) && (r_path_count != '0) && !w_div_busy;

    mc_seq_divider #(
        .DVD_W(ACC_W),
        .DVS_W(CNT_W),
        .QUO_W(DATA_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_div_start),
        .i_dividend(w_acc_sum),
        .i_divisor (r_path_count),
        .o_busy    (w_div_busy),
        .o_done    (w_div_done),
        .o_quotient(w_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)        w_next = ST_ACCUM;
            ST_ACCUM:  if (engine_done)  w_next = ST_DRAIN;
            ST_DRAIN:  w_next = (r_path_count == '0) ? ST_HOLD : ST_DIVIDE;
            ST_DIVIDE: if (w_div_done)   w_next = ST_HOLD;
            ST_HOLD:   if (result_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Stage 1: payoff of the accepted path
    always_ff @(posedge clk) begin
        r_pay_p1 <= call_payoff(path_price, r_strike);
        if ((r_state == ST_IDLE) && start) begin
            r_strike <= strike;
        end
    end

    // Stage 2: accumulation, counters, result and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1       <= 1'b0;
            r_acc          <= '0;
            r_path_count   <= '0;
            r_result       <= '0;
            r_err_no_paths <= 1'b0;
            r_err_excess   <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if ((r_state == ST_IDLE) && start) begin
                r_acc          <= '0;
                r_path_count   <= '0;
                r_err_no_paths <= 1'b0;
                r_err_excess   <= 1'b0;
            end else begin
                if (r_vld_p1)  r_acc        <= w_acc_sum;
                if (w_accept)  r_path_count <= r_path_count + 1'b1;
                if (w_excess)  r_err_excess <= 1'b1;
                if ((r_state == ST_DRAIN) && (r_path_count == '0)) begin
                    r_result       <= '0;
                    r_err_no_paths <= 1'b1;
                end
                if ((r_state == ST_DIVIDE) && w_div_done) begin
                    r_result <= w_quotient;
                end
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign result_valid = (r_state == ST_HOLD);
    assign path_count   = r_path_count;
    assign result_price = r_result;
    assign err_no_paths = r_err_no_paths;
    assign err_excess   = r_err_excess;

endmodule

// File: tb/tb_mc_payoff_collector.sv
// Scoreboard bench: two collectors (default path limit and a limit of 3) share stimulus.
module tb_mc_payoff_collector;

    localparam int NP_A     = 100000;
    localparam int NP_B     = 3;
    localparam int ACC_W    = 32 + 17;
    localparam int LAT_FULL = ACC_W + 3;

    typedef struct {
        int          cnt;
        logic [31:0] price;
        bit          nop;
        bit          exc;
        int          dcyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, path_valid, engine_done, result_ready;
    logic [31:0] strike, path_price;

    logic        a_busy, a_valid, a_nop, a_exc;
    logic [16:0] a_cnt;
    logic [31:0] a_price;
    logic        b_busy, b_valid, b_nop, b_exc;
    logic [16:0] b_cnt;
    logic [31:0] b_price;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] price_q[$];
    logic [31:0] offered_q[$];
    exp_t        sbq_a[$];
    exp_t        sbq_b[$];
    bit          prev_valid[2];
    bit          prev_ready[2];
    logic [31:0] prev_price[2];

    mc_payoff_collector dut_a (
        .clk(clk), .rst(rst), .start(start), .strike(strike),
        .path_valid(path_valid), .path_price(path_price), .engine_done(engine_done),
        .busy(a_busy), .path_count(a_cnt), .result_valid(a_valid),
        .result_ready(result_ready), .result_price(a_price),
        .err_no_paths(a_nop), .err_excess(a_exc)
    );

    mc_payoff_collector #(.NUM_PATHS(NP_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .strike(strike),
        .path_valid(path_valid), .path_price(path_price), .engine_done(engine_done),
        .busy(b_busy), .path_count(b_cnt), .result_valid(b_valid),
        .result_ready(result_ready), .result_price(b_price),
        .err_no_paths(b_nop), .err_excess(b_exc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: mean of max(S-K,0) over the first np offered paths, truncated.
    function automatic exp_t model(input logic [31:0] k, input int np, input int dcyc);
        exp_t            e;
        longint unsigned sum;
        sum   = 0;
        e.cnt = 0;
        e.exc = 0;
        foreach (offered_q[i]) begin
            if (e.cnt < np) begin
                e.cnt++;
                if (offered_q[i] > k) sum += longint'(offered_q[i] - k);
            end else begin
                e.exc = 1;
            end
        end
        e.nop   = (e.cnt == 0);
        e.price = (e.cnt == 0) ? 32'd0 : 32'(sum / longint'(e.cnt));
        e.lat   = (e.cnt == 0) ? 2 : LAT_FULL;
        e.dcyc  = dcyc;
        return e;
    endfunction

    task automatic mon(input int w, input logic valid, input logic bsy, input logic [16:0] cnt,
                       input logic [31:0] price, input logic nop, input logic exc);
        exp_t  e;
        string p;
        p = (w == 0) ? "a" : "b";
        if (!rst) begin
            if (valid && !prev_valid[w]) begin
                if ((w == 0 && sbq_a.size() == 0) || (w == 1 && sbq_b.size() == 0)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s_unexpected_result: got valid, expected none", p);
                end else begin
                    e = (w == 0) ? sbq_a.pop_front() : sbq_b.pop_front();
                    chk({p, "_result_price"}, price, e.price);
                    chk({p, "_path_count"}, cnt, e.cnt);
                    chk({p, "_err_no_paths"}, nop, e.nop);
                    chk({p, "_err_excess"}, exc, e.exc);
                    chk({p, "_latency"}, cyc - e.dcyc, e.lat);
                end
            end
            if (prev_valid[w] && !prev_ready[w]) begin
                chk({p, "_hold_valid"}, valid, 1);
                chk({p, "_hold_price"}, price, prev_price[w]);
            end
            if (prev_valid[w] && prev_ready[w]) begin
                chk({p, "_idle_busy"}, bsy, 0);
                chk({p, "_idle_valid"}, valid, 0);
            end
        end
        prev_valid[w] = valid;
        prev_ready[w] = result_ready;
        prev_price[w] = price;
    endtask

    always @(negedge clk) begin
        mon(0, a_valid, a_busy, a_cnt, a_price, a_nop, a_exc);
        mon(1, b_valid, b_busy, b_cnt, b_price, b_nop, b_exc);
    end

    task automatic chk_reset();
        chk("a_rst_busy", a_busy, 0);   chk("b_rst_busy", b_busy, 0);
        chk("a_rst_valid", a_valid, 0); chk("b_rst_valid", b_valid, 0);
        chk("a_rst_price", a_price, 0); chk("b_rst_price", b_price, 0);
        chk("a_rst_count", a_cnt, 0);   chk("b_rst_count", b_cnt, 0);
        chk("a_rst_nop", a_nop, 0);     chk("b_rst_nop", b_nop, 0);
        chk("a_rst_exc", a_exc, 0);     chk("b_rst_exc", b_exc, 0);
    endtask

    task automatic run_case(input logic [31:0] k, input bit coincide, input bit gaps,
                            input int rwait, input bit start_in_hold, input bit abort);
        int dcyc;
        int t;
        offered_q.delete();
        start  = 1'b1;
        strike = k;
        tick();
        start  = 1'b0;
        strike = $urandom;
        dcyc   = 0;
        foreach (price_q[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                path_valid = 1'b0;
                tick();
            end
            path_valid = 1'b1;
            path_price = price_q[i];
            offered_q.push_back(price_q[i]);
            if (coincide && i == price_q.size() - 1) begin
                engine_done = 1'b1;
                dcyc = cyc;
            end
            tick();
        end
        if (!coincide || price_q.size() == 0) begin
            path_valid  = 1'b0;
            engine_done = 1'b1;
            dcyc = cyc;
            tick();
        end
        engine_done = 1'b0;
        if (!abort) begin
            sbq_a.push_back(model(k, NP_A, dcyc));
            sbq_b.push_back(model(k, NP_B, dcyc));
        end
        // Paths and a start pulse after done must both be ignored.
        path_valid = 1'b1;
        repeat (3) begin
            path_price = $urandom;
            tick();
        end
        path_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (abort) begin
            repeat (8) tick();
            rst = 1'b1;
            tick();
            chk_reset();
            rst = 1'b0;
            tick();
            return;
        end
        t = 0;
        while (!a_valid && t < 200) begin
            tick();
            t++;
        end
        if (!a_valid) chk("result_timeout", a_valid, 1);
        for (int i = 0; i < rwait; i++) begin
            if (start_in_hold && i == rwait / 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] k;
        rst = 1'b1; start = 1'b0; strike = '0; path_valid = 1'b0;
        path_price = '0; engine_done = 1'b0; result_ready = 1'b0;
        repeat (3) tick();
        chk_reset();
        rst = 1'b0;
        tick();

        price_q = {32'h006E_0000, 32'h005A_0000, 32'h0078_0000, 32'h0064_0000};
        run_case(32'h0064_0000, 0, 0, 2, 0, 0);

        price_q.delete();
        run_case(32'h0064_0000, 0, 0, 1, 0, 0);

        price_q = {32'h0069_0000, 32'h0069_0000, 32'h0069_0000, 32'h0069_0000};
        run_case(32'h0064_0000, 0, 0, 0, 0, 0);

        price_q = {32'h006E_0000, 32'h005A_0000, 32'h0078_0000, 32'h0064_0000};
        run_case(32'h0064_0000, 0, 0, 10, 1, 0);

        price_q = {32'h00C8_0000};
        run_case(32'h0064_0000, 1, 0, 1, 0, 0);

        price_q = {32'h006E_0000, 32'h005A_0000, 32'h0078_0000, 32'h0064_0000};
        run_case(32'h0064_0000, 0, 0, 0, 0, 1);
        run_case(32'h0064_0000, 0, 0, 1, 0, 0);

        for (int r = 0; r < 12; r++) begin
            k = (32'($urandom_range(50, 150)) << 16) | 32'($urandom_range(0, 65535));
            price_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 8)); i++)
                price_q.push_back(k - 32'h0014_0000 + 32'($urandom_range(0, 32'h0028_0000)));
            run_case(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
        end

        if (sbq_a.size() != 0 || sbq_b.size() != 0) chk("scoreboard_leftover", sbq_a.size() + sbq_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
